// File: rtl/ppu_pkg.sv
// -----------------------------------------------------------------------------
// ppu_pkg
//   Shared elaboration-time helpers for the PPU datapath blocks.
//   - clog2     : ceiling log2, clog2(1) = 0
//   - sat_max   : saturation ceiling for a given width / signedness
//   - sat_min   : saturation floor for a given width / signedness
//   The saturation helpers return SAT_W_MAX-bit vectors; callers truncate
//   to their own DATA_WIDTH (DATA_WIDTH must not exceed SAT_W_MAX).
// -----------------------------------------------------------------------------
package ppu_pkg;

  localparam int SAT_W_MAX = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Unsigned: all ones. Signed: 0111..1.
  function automatic logic [SAT_W_MAX-1:0] sat_max(input int width, input bit signed_mode);
    logic [SAT_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (i < width - (signed_mode ? 1 : 0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Unsigned: zero. Signed: 1000..0.
  function automatic logic [SAT_W_MAX-1:0] sat_min(input int width, input bit signed_mode);
    logic [SAT_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (signed_mode && (i == width - 1)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add_node.sv
// -----------------------------------------------------------------------------
// sat_add_node
//   One combinational node of the saturating adder tree: sum = sat(a + b).
//   Ports:
//     a, b : DATA_WIDTH-bit operands (unsigned or two's complement)
//     sum  : saturated DATA_WIDTH-bit result
//     sat  : 1 when the result was clamped
// -----------------------------------------------------------------------------
module sat_add_node
  import ppu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SIGNED_MODE = 0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  sat
);

  localparam bit                  SGN   = (SIGNED_MODE != 0);
  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(sat_max(DATA_WIDTH, SGN));
  localparam logic [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(sat_min(DATA_WIDTH, SGN));

  logic [DATA_WIDTH:0] a_x;
  logic [DATA_WIDTH:0] b_x;
  logic [DATA_WIDTH:0] full;

  assign a_x  = {(SGN & a[DATA_WIDTH-1]), a};
  assign b_x  = {(SGN & b[DATA_WIDTH-1]), b};
  assign full = a_x + b_x;

  // Signed: the extended sum's top bit is the true sign; overflow whenever it
  // disagrees with the DATA_WIDTH-bit sign. Unsigned: overflow is the carry.
  assign sat = SGN ? (full[DATA_WIDTH] ^ full[DATA_WIDTH-1]) : full[DATA_WIDTH];

  assign sum = !sat                   ? full[DATA_WIDTH-1:0] :
               (SGN && full[DATA_WIDTH]) ? MIN_V : MAX_V;

endmodule

// File: rtl/pipe_sat_adder_tree.sv
// -----------------------------------------------------------------------------
// pipe_sat_adder_tree
//   Pipelined saturating adder tree: reduces LENGTH DATA_WIDTH-bit addends to
//   one saturated sum, one sample per cycle, with valid/ready flow control.
//   Addends are zero-padded to a power of two and reduced pairwise, level by
//   level (node k of a level = sat(in[2k] + in[2k+1])). A register stage sits
//   after every REG_EVERY-th level and the output is always registered, giving
//   LAT = max(1, ceil(LEVELS/REG_EVERY)).
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     in_valid    : input sample valid
//     in_ready    : sample accepted this cycle (= !out_valid || out_ready)
//     in_addends  : addend i at [i*DATA_WIDTH +: DATA_WIDTH]
//     out_valid   : out_sum/out_sat valid
//     out_ready   : downstream accepts the output
//     out_sum     : saturated sum
//     out_sat     : any node in this sample's tree saturated
// -----------------------------------------------------------------------------
module pipe_sat_adder_tree
  import ppu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LENGTH      = 128,
  parameter int SIGNED_MODE = 0,
  parameter int REG_EVERY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*LENGTH-1:0] in_addends,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_sum,
  output logic                         out_sat
);

  localparam int W      = DATA_WIDTH;
  localparam int LEVELS = clog2(LENGTH);
  localparam int P      = 1 << LEVELS;
  localparam int LAT    = (LEVELS == 0) ? 1 : (LEVELS + REG_EVERY - 1) / REG_EVERY;

  // Whole pipeline advances together; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Leaves: addends zero-padded to P entries
  // ---------------------------------------------------------------------------
  logic [P*W-1:0] leaf_data;

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < LENGTH) begin : g_real
      assign leaf_data[k*W +: W] = in_addends[k*W +: W];
    end else begin : g_pad
      assign leaf_data[k*W +: W] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Tree levels. lvl_sat carries, per node, the OR of every sat bit in that
  // node's subtree, so the root bit is the per-sample flag. The root level is
  // left combinational because the output register below closes it.
  // ---------------------------------------------------------------------------
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N = P >> l;

    logic [2*N*W-1:0] src_data;
    logic [2*N-1:0]   src_sat;
    logic [N*W-1:0]   lvl_data;
    logic [N-1:0]     lvl_sat;

    if (l == 1) begin : g_src_leaf
      assign src_data = leaf_data;
      assign src_sat  = '0;
    end else begin : g_src_lvl
      assign src_data = g_lvl[l-1].lvl_data;
      assign src_sat  = g_lvl[l-1].lvl_sat;
    end

    for (genvar k = 0; k < N; k++) begin : g_node
      logic [W-1:0] sum_c;
      logic         node_sat;
      logic         sat_d;

      sat_add_node #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SIGNED_MODE (SIGNED_MODE)
      ) u_node (
        .a   (src_data[(2*k)*W +: W]),
        .b   (src_data[(2*k+1)*W +: W]),
        .sum (sum_c),
        .sat (node_sat)
      );

      assign sat_d = node_sat | src_sat[2*k] | src_sat[2*k+1];

      if ((l % REG_EVERY == 0) && (l < LEVELS)) begin : g_reg
        logic [W-1:0] sum_q;
        logic         sat_q;

        // NOTE: intermediate data registers are deliberately not reset; the
        // valid shift register alone decides whether a stage holds a sample.
        always_ff @(posedge clk) begin
          if (adv) begin
            sum_q <= sum_c;
            sat_q <= sat_d;
          end
        end

        assign lvl_data[k*W +: W] = sum_q;
        assign lvl_sat[k]         = sat_q;
      end else begin : g_comb
        assign lvl_data[k*W +: W] = sum_c;
        assign lvl_sat[k]         = sat_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Root selection (LENGTH == 1 passes the single addend straight through)
  // ---------------------------------------------------------------------------
  logic [W-1:0] root_sum;
  logic         root_sat;

  if (LEVELS == 0) begin : g_root_leaf
    assign root_sum = leaf_data;
    assign root_sat = 1'b0;
  end else begin : g_root_tree
    assign root_sum = g_lvl[LEVELS].lvl_data;
    assign root_sat = g_lvl[LEVELS].lvl_sat[0];
  end

  // ---------------------------------------------------------------------------
  // Valid shift register (one bit per register stage) and output register
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [W-1:0]   out_sum_q;
  logic           out_sat_q;

  // NOTE: vld_d gets a full default first so no path leaves it unassigned,
  // which keeps this block purely combinational (no latch).
  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int s = 1; s < LAT; s++) vld_d[s] = vld_q[s-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      out_sum_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (adv) begin
        out_sum_q <= root_sum;
        out_sat_q <= root_sat;
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pipe_sat_adder_tree.sv
// -----------------------------------------------------------------------------
// tb_pipe_sat_adder_tree
//   Four configurations of pipe_sat_adder_tree:
//     A: W=8 L=4   unsigned REG_EVERY=1 (LAT 2)
//     B: W=8 L=4   signed   REG_EVERY=1 (LAT 2)
//     C: W=8 L=5   unsigned REG_EVERY=2 (LAT 2)
//     D: W=8 L=128 unsigned REG_EVERY=1 (LAT 7)
//   Inputs are driven and outputs sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipe_sat_adder_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT A ----------------
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_sat;
  logic [31:0] a_addends = '0;
  logic [7:0]  a_out_sum;
  pipe_sat_adder_tree #(.DATA_WIDTH(8), .LENGTH(4), .SIGNED_MODE(0), .REG_EVERY(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addends(a_addends),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .out_sat(a_out_sat));

  // ---------------- DUT B ----------------
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_sat;
  logic [31:0] b_addends = '0;
  logic [7:0]  b_out_sum;
  pipe_sat_adder_tree #(.DATA_WIDTH(8), .LENGTH(4), .SIGNED_MODE(1), .REG_EVERY(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addends(b_addends),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_sat(b_out_sat));

  // ---------------- DUT C ----------------
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_out_sat;
  logic [39:0] c_addends = '0;
  logic [7:0]  c_out_sum;
  pipe_sat_adder_tree #(.DATA_WIDTH(8), .LENGTH(5), .SIGNED_MODE(0), .REG_EVERY(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_addends(c_addends),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum), .out_sat(c_out_sat));

  // ---------------- DUT D ----------------
  logic          d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b1, d_out_sat;
  logic [1023:0] d_addends = '0;
  logic [7:0]    d_out_sum;
  pipe_sat_adder_tree #(.DATA_WIDTH(8), .LENGTH(128), .SIGNED_MODE(0), .REG_EVERY(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_addends(d_addends),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_sum(d_out_sum), .out_sat(d_out_sat));

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] pack5(input logic [7:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Reference: zero-pad to a power of two, reduce pairwise with clamping on
  // plain integers. Returns {sat, sum}.
  function automatic logic [8:0] tree_model(input logic [1023:0] v, input int len, input bit sgn);
    int val [128];
    int n;
    int s;
    bit sat;
    n   = 1;
    sat = 1'b0;
    while (n < len) n = n * 2;
    for (int i = 0; i < 128; i++) begin
      if (i >= len)  val[i] = 0;
      else if (sgn)  val[i] = int'($signed(v[i*8 +: 8]));
      else           val[i] = int'(v[i*8 +: 8]);
    end
    while (n > 1) begin
      for (int k = 0; k < n / 2; k++) begin
        s = val[2*k] + val[2*k+1];
        if (sgn) begin
          if (s > 127)  begin s = 127;  sat = 1'b1; end
          if (s < -128) begin s = -128; sat = 1'b1; end
        end else if (s > 255) begin
          s = 255; sat = 1'b1;
        end
        val[k] = s;
      end
      n = n / 2;
    end
    return {sat, val[0][7:0]};
  endfunction

  task automatic set_in(input int id, input logic valid, input logic [39:0] add);
    case (id)
      0:       begin a_in_valid = valid; a_addends = add[31:0]; end
      1:       begin b_in_valid = valid; b_addends = add[31:0]; end
      default: begin c_in_valid = valid; c_addends = add;       end
    endcase
  endtask

  task automatic get_out(input int id, output logic v, output logic [7:0] s, output logic st);
    case (id)
      0:       begin v = a_out_valid; s = a_out_sum; st = a_out_sat; end
      1:       begin v = b_out_valid; s = b_out_sum; st = b_out_sat; end
      default: begin v = c_out_valid; s = c_out_sum; st = c_out_sat; end
    endcase
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;
    logic [39:0] add;
    logic [7:0]  exp_sum;
    logic        exp_sat;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    logic       ov;
    logic [7:0] os;
    logic       ost;
    int         lat;
    lat = -1;
    os  = '0;
    ost = 1'b0;
    @(negedge clk);
    set_in(v.dut, 1'b1, v.add);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_in(v.dut, 1'b0, '0);
      #1;
      get_out(v.dut, ov, os, ost);
      if (ov) begin
        lat = cyc;
        break;
      end
    end
    check({v.name, "_lat"}, lat, v.exp_lat);
    check({v.name, "_sum"}, os, v.exp_sum);
    check({v.name, "_sat"}, ost, v.exp_sat);
  endtask

  // ---------------- main sequence ----------------
  logic [1023:0] beats [20];
  logic [8:0]    q [$];

  initial begin
    // Unsigned L=4
    vecs.push_back('{0, pack5(8'd10,  8'd20,  8'd30, 8'd40, 8'd0), 8'd100, 1'b0, 2, "u_basic"});
    vecs.push_back('{0, pack5(8'd200, 8'd100, 8'd1,  8'd1,  8'd0), 8'd255, 1'b1, 2, "u_sat_l1"});
    vecs.push_back('{0, pack5(8'd128, 8'd127, 8'd0,  8'd0,  8'd0), 8'd255, 1'b0, 2, "u_exact_max"});
    vecs.push_back('{0, pack5(8'd128, 8'd128, 8'd0,  8'd0,  8'd0), 8'd255, 1'b1, 2, "u_one_over"});
    vecs.push_back('{0, pack5(8'd100, 8'd100, 8'd100, 8'd100, 8'd0), 8'd255, 1'b1, 2, "u_sat_root"});
    vecs.push_back('{0, pack5(8'd0,   8'd0,   8'd0,  8'd0,  8'd0), 8'd0,   1'b0, 2, "u_zero"});
    // Signed L=4
    vecs.push_back('{1, pack5(8'd127, 8'd1,   8'h80, 8'd0,  8'd0), 8'hFF,  1'b1, 2, "s_mixed"});
    vecs.push_back('{1, pack5(8'hFF,  8'hFF,  8'hFF, 8'hFF, 8'd0), 8'hFC,  1'b0, 2, "s_neg"});
    vecs.push_back('{1, pack5(8'h80,  8'hFF,  8'd1,  8'd2,  8'd0), 8'h83,  1'b1, 2, "s_min_sat"});
    vecs.push_back('{1, pack5(8'd100, 8'd27,  8'd0,  8'd0,  8'd0), 8'd127, 1'b0, 2, "s_exact_max"});
    vecs.push_back('{1, pack5(8'hC0,  8'hC0,  8'hFF, 8'd0,  8'd0), 8'h80,  1'b1, 2, "s_root_min"});
    // Unsigned L=5, REG_EVERY=2
    vecs.push_back('{2, pack5(8'd1,   8'd2,   8'd3,  8'd4,  8'd5), 8'd15,  1'b0, 2, "c_pad"});
    vecs.push_back('{2, pack5(8'd255, 8'd255, 8'd0,  8'd0,  8'd1), 8'd255, 1'b1, 2, "c_sat"});
    vecs.push_back('{2, pack5(8'd0,   8'd0,   8'd0,  8'd0,  8'd255), 8'd255, 1'b0, 2, "c_last"});

    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < 128; j++) begin
        beats[b][j*8 +: 8] = (b % 2 == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      end
    end

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_in_ready",  a_in_ready,  1'b1);
    check("rst_a_out_sum",   a_out_sum,   8'd0);
    check("rst_a_out_sat",   a_out_sat,   1'b0);
    check("rst_d_out_valid", d_out_valid, 1'b0);
    check("rst_d_in_ready",  d_in_ready,  1'b1);

    // Table-driven single samples
    foreach (vecs[i]) run_vec(vecs[i]);

    // Streaming with output stalls on DUT D
    begin
      int  beat_idx;
      int  oc;
      int  got;
      bit  started;
      bit  stall;
      beat_idx = 0;
      oc       = 0;
      got      = 0;
      started  = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
        @(negedge clk);
        if (d_out_valid) started = 1'b1;
        stall       = started && (oc == 5 || oc == 6 || oc == 7 || oc == 12);
        d_out_ready = !stall;
        if (beat_idx < 20) begin
          d_in_valid = 1'b1;
          d_addends  = beats[beat_idx];
        end else begin
          d_in_valid = 1'b0;
        end
        #1;
        if (started && oc < 20) check($sformatf("stream_in_ready_oc%0d", oc), d_in_ready, !stall);
        if (d_out_valid) begin
          if (q.size() == 0) begin
            check("stream_unexpected_out_valid", d_out_valid, 1'b0);
          end else begin
            check($sformatf("stream_sum_oc%0d", oc), d_out_sum, q[0][7:0]);
            check($sformatf("stream_sat_oc%0d", oc), d_out_sat, q[0][8]);
            if (d_out_ready) begin
              void'(q.pop_front());
              got++;
            end
          end
        end
        if (d_in_valid && d_in_ready) begin
          q.push_back(tree_model(beats[beat_idx], 128, 1'b0));
          beat_idx++;
        end
        if (started) oc++;
      end
      check("stream_beats_out", got, 20);
      @(negedge clk);
      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      #1;
      check("stream_drained_valid", d_out_valid, 1'b0);
    end

    // Mid-stream reset on DUT D
    begin
      logic [1023:0] drop_v;
      logic [1023:0] fresh;
      logic [8:0]    exp_fresh;
      int            n_out;
      int            lat;
      n_out = 0;
      lat   = -1;
      for (int j = 0; j < 128; j++) fresh[j*8 +: 8] = 8'(j % 2);
      exp_fresh = tree_model(fresh, 128, 1'b0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        for (int j = 0; j < 128; j++) drop_v[j*8 +: 8] = (j == 0) ? 8'(200 + i) : 8'd0;
        d_in_valid = 1'b1;
        d_addends  = drop_v;
      end
      @(negedge clk);
      rst       = 1'b1;
      d_addends = '1;
      @(negedge clk);
      #1;
      check("midrst_out_valid", d_out_valid, 1'b0);
      check("midrst_out_sum",   d_out_sum,   8'd0);
      check("midrst_out_sat",   d_out_sat,   1'b0);
      rst        = 1'b0;
      d_in_valid = 1'b1;
      d_addends  = fresh;
      #1;
      check("midrst_in_ready", d_in_ready, 1'b1);
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(negedge clk);
        if (cyc == 1) d_in_valid = 1'b0;
        #1;
        if (d_out_valid) begin
          n_out++;
          if (lat < 0) begin
            lat = cyc;
            check("midrst_fresh_sum", d_out_sum, exp_fresh[7:0]);
            check("midrst_fresh_sat", d_out_sat, exp_fresh[8]);
          end
        end
      end
      check("midrst_fresh_lat", lat, 7);
      check("midrst_out_count", n_out, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
